// File: rtl/rtc_pkg.sv
// Shared constants for the time-of-day clock: segment patterns, set_sel
// encodings, the decoded operating mode and the BCD-to-segment decoder.
package rtc_pkg;

  localparam logic [6:0] SEG_0     = 7'h7e;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6d;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5b;
  localparam logic [6:0] SEG_6     = 7'h5f;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7f;
  localparam logic [6:0] SEG_9     = 7'h7b;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] SEL_RUN = 2'b00;
  localparam logic [1:0] SEL_HR  = 2'b01;
  localparam logic [1:0] SEL_MIN = 2'b10;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_SET_HR,
    MODE_SET_MIN
  } mode_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = SEG_0;
      4'd1:    bcd_to_seg = SEG_1;
      4'd2:    bcd_to_seg = SEG_2;
      4'd3:    bcd_to_seg = SEG_3;
      4'd4:    bcd_to_seg = SEG_4;
      4'd5:    bcd_to_seg = SEG_5;
      4'd6:    bcd_to_seg = SEG_6;
      4'd7:    bcd_to_seg = SEG_7;
      4'd8:    bcd_to_seg = SEG_8;
      4'd9:    bcd_to_seg = SEG_9;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-DIV counter; tick is high for the whole cycle in which
// the count sits at DIV-1, giving a one-cycle clock enable per period.
module tick_gen #(
  parameter  int DIV = 4,
  localparam int W   = $clog2(DIV)
) (
  input  logic         clk,
  input  logic         rst,
  output logic         tick,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/rtc_display_ctrl.sv
// Time-of-day clock with BCD counters, hour/minute setting, 12/24-hour display
// conversion and a registered multiplexed seven-segment scan driver.
module rtc_display_ctrl
  import rtc_pkg::*;
#(
  parameter  int TICK_DIV = 100000000,
  parameter  int SCAN_DIV = 25000,
  parameter  int SHOW_SEC = 0,
  localparam int NDIG     = 4 + 2 * SHOW_SEC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode_24,
  input  logic [1:0]      set_sel,
  input  logic            inc,
  output logic [NDIG-1:0] an,
  output logic [6:0]      seg,
  output logic            dp,
  output logic            pm,
  output logic            sec_tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] HALF     = TW'(TICK_DIV / 2);
  localparam logic [2:0]    LAST_IDX = 3'(NDIG - 1);

  logic [TW-1:0]   pre_count;
  logic            scan_step;
  logic [SW-1:0]   unused_scan_count;
  mode_e           mode;

  // Time in packed BCD: {tens, units}
  logic [6:0]      ss, ss_next;
  logic [6:0]      mm, mm_next;
  logic [5:0]      hh, hh_next;

  logic [2:0]      scan_idx;
  logic [2:0]      pos;
  logic [3:0]      digit;
  logic            blank;
  logic            blink_on;
  logic [NDIG-1:0] an_next;

  logic [4:0]      hour_bin;
  logic [4:0]      disp_bin;
  logic [1:0]      disp_t;
  logic [3:0]      disp_u;

  tick_gen #(.DIV(TICK_DIV)) u_sec_tick (
    .clk   (clk),
    .rst   (rst),
    .tick  (sec_tick),
    .count (pre_count)
  );

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk   (clk),
    .rst   (rst),
    .tick  (scan_step),
    .count (unused_scan_count)
  );

  // Shared by seconds and minutes: 00..59 with wrap
  function automatic logic [6:0] sexa_inc(input logic [6:0] v);
    if (v[3:0] != 4'd9) begin
      sexa_inc = {v[6:4], v[3:0] + 4'd1};
    end else if (v[6:4] != 3'd5) begin
      sexa_inc = {v[6:4] + 3'd1, 4'd0};
    end else begin
      sexa_inc = 7'd0;
    end
  endfunction

  function automatic logic [5:0] hour_inc(input logic [5:0] v);
    if (v == 6'h23) begin
      hour_inc = 6'd0;
    end else if (v[3:0] == 4'd9) begin
      hour_inc = {v[5:4] + 2'd1, 4'd0};
    end else begin
      hour_inc = {v[5:4], v[3:0] + 4'd1};
    end
  endfunction

  always_comb begin
    case (set_sel)
      SEL_HR:  mode = MODE_SET_HR;
      SEL_MIN: mode = MODE_SET_MIN;
      default: mode = MODE_RUN;
    endcase
  end

  // The whole seconds-to-hours carry chain resolves within a single tick
  always_comb begin
    ss_next = ss;
    mm_next = mm;
    hh_next = hh;
    case (mode)
      MODE_RUN: begin
        if (sec_tick) begin
          ss_next = sexa_inc(ss);
          if (ss == 7'h59) begin
            mm_next = sexa_inc(mm);
            if (mm == 7'h59) begin
              hh_next = hour_inc(hh);
            end
          end
        end
      end
      MODE_SET_HR: begin
        ss_next = 7'd0;
        if (inc) begin
          hh_next = hour_inc(hh);
        end
      end
      MODE_SET_MIN: begin
        ss_next = 7'd0;
        if (inc) begin
          mm_next = sexa_inc(mm);
        end
      end
      default: begin
        ss_next = ss;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss <= '0;
      mm <= '0;
      hh <= '0;
    end else begin
      ss <= ss_next;
      mm <= mm_next;
      hh <= hh_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_idx <= '0;
    end else if (scan_step) begin
      scan_idx <= (scan_idx == LAST_IDX) ? 3'd0 : scan_idx + 3'd1;
    end
  end

  always_comb begin
    hour_bin = 5'(hh[5:4]) * 5'd10 + 5'(hh[3:0]);
    disp_bin = hour_bin;
    if (!mode_24) begin
      if (hour_bin == 5'd0) begin
        disp_bin = 5'd12;
      end else if (hour_bin > 5'd12) begin
        disp_bin = hour_bin - 5'd12;
      end
    end
    if (disp_bin >= 5'd20) begin
      disp_t = 2'd2;
    end else if (disp_bin >= 5'd10) begin
      disp_t = 2'd1;
    end else begin
      disp_t = 2'd0;
    end
    disp_u = 4'(disp_bin - 5'(disp_t) * 5'd10);
  end

  // pos maps the scan index onto the six-digit layout so 4-digit builds skip seconds
  always_comb begin
    digit    = 4'd0;
    blank    = 1'b0;
    blink_on = (pre_count >= HALF);
    pos      = (SHOW_SEC != 0) ? scan_idx : scan_idx + 3'd2;
    case (pos)
      3'd0:    digit = ss[3:0];
      3'd1:    digit = {1'b0, ss[6:4]};
      3'd2:    digit = mm[3:0];
      3'd3:    digit = {1'b0, mm[6:4]};
      3'd4:    digit = disp_u;
      default: begin
        digit = {2'b00, disp_t};
        blank = !mode_24 && (disp_t == 2'd0);
      end
    endcase
    if (blink_on && (mode == MODE_SET_HR) && (pos >= 3'd4)) begin
      blank = 1'b1;
    end
    if (blink_on && (mode == MODE_SET_MIN) && ((pos == 3'd2) || (pos == 3'd3))) begin
      blank = 1'b1;
    end
    an_next = {{(NDIG-1){1'b0}}, 1'b1} << scan_idx;
  end

  // an and seg share one register stage so the digit and its pattern switch together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= '0;
      seg <= SEG_BLANK;
      dp  <= 1'b0;
      pm  <= 1'b0;
    end else begin
      an  <= an_next;
      seg <= blank ? SEG_BLANK : bcd_to_seg(digit);
      dp  <= (scan_idx == 3'd2) && !ss[0];
      pm  <= (hh >= 6'h12);
    end
  end

endmodule

// File: tb/tb_rtc_display_ctrl.sv
// Bench for rtc_display_ctrl: a time-of-day reference model advanced per clock
// edge predicts every registered output; scenario tasks add targeted checks.
module tb_rtc_display_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int SHOW_SEC = 1;
  localparam int NDIG     = 6;

  localparam logic [6:0] SEG_TBL [10] = '{7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33,
                                          7'h5b, 7'h5f, 7'h70, 7'h7f, 7'h7b};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mode_24 = 1'b1;
  logic [1:0]      set_sel = 2'b00;
  logic            inc = 1'b0;
  logic [NDIG-1:0] an;
  logic [6:0]      seg;
  logic            dp;
  logic            pm;
  logic            sec_tick;

  int tests = 0;
  int fails = 0;

  // Reference model state: plain integers for time, prescaler and scan position
  int m_hh, m_mm, m_ss, m_pre, m_spre, m_idx;
  logic [5:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_pm;

  rtc_display_ctrl #(
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV),
    .SHOW_SEC (SHOW_SEC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_24  (mode_24),
    .set_sel  (set_sel),
    .inc      (inc),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .pm       (pm),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic mdl_reset();
    m_hh = 0; m_mm = 0; m_ss = 0; m_pre = 0; m_spre = 0; m_idx = 0;
    e_an = '0; e_seg = '0; e_dp = 1'b0; e_pm = 1'b0;
  endtask

  // Registered outputs capture the pre-edge view; then time and counters advance
  task automatic mdl_edge();
    int  dig[6];
    int  dh, t;
    bit  blank, blink;
    dh = mode_24 ? m_hh : ((m_hh % 12 == 0) ? 12 : m_hh % 12);
    dig[0] = m_ss % 10; dig[1] = m_ss / 10;
    dig[2] = m_mm % 10; dig[3] = m_mm / 10;
    dig[4] = dh % 10;   dig[5] = dh / 10;
    blink = (m_pre >= TICK_DIV / 2);
    blank = (m_idx == 5) && !mode_24 && (dh < 10);
    if (set_sel == 2'b01 && m_idx >= 4 && blink) blank = 1;
    if (set_sel == 2'b10 && (m_idx == 2 || m_idx == 3) && blink) blank = 1;
    e_an  = 6'(1 << m_idx);
    e_seg = blank ? 7'h00 : SEG_TBL[dig[m_idx]];
    e_dp  = (m_idx == 2) && (m_ss % 2 == 0);
    e_pm  = (m_hh >= 12);
    if (set_sel == 2'b00 || set_sel == 2'b11) begin
      if (m_pre == TICK_DIV - 1) begin
        t = ((m_hh * 60 + m_mm) * 60 + m_ss + 1) % 86400;
        m_hh = t / 3600; m_mm = (t / 60) % 60; m_ss = t % 60;
      end
    end else begin
      m_ss = 0;
      if (inc) begin
        if (set_sel == 2'b01) m_hh = (m_hh + 1) % 24;
        else                  m_mm = (m_mm + 1) % 60;
      end
    end
    if (m_spre == SCAN_DIV - 1) m_idx = (m_idx + 1) % NDIG;
    m_spre = (m_spre + 1) % SCAN_DIV;
    m_pre  = (m_pre + 1) % TICK_DIV;
  endtask

  function automatic logic [15:0] expected();
    return {e_an, e_seg, e_dp, e_pm, (m_pre == TICK_DIV - 1)};
  endfunction

  function automatic logic [15:0] observed();
    return {an, seg, dp, pm, sec_tick};
  endfunction

  task automatic step();
    @(posedge clk);
    mdl_edge();
    @(negedge clk);
  endtask

  // Stimulus only: drive back-to-back inc pulses until the model field hits target
  task automatic set_field(input logic [1:0] sel, input int target);
    set_sel = sel;
    for (int n = 0; n < 64; n++) begin
      if (((sel == 2'b01) ? m_hh : m_mm) == target) break;
      inc = 1'b1;
      step();
    end
    inc = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    mdl_reset();
    #1;
    tests++; if (an !== '0)      begin fails++; $display("[TB] FAIL reset_an: got %b want 0", an); end
    tests++; if (seg !== '0)     begin fails++; $display("[TB] FAIL reset_seg: got %h want 0", seg); end
    tests++; if (dp !== 1'b0)    begin fails++; $display("[TB] FAIL reset_dp: got %b want 0", dp); end
    tests++; if (pm !== 1'b0)    begin fails++; $display("[TB] FAIL reset_pm: got %b want 0", pm); end
    tests++; if (sec_tick !== 1'b0) begin fails++; $display("[TB] FAIL reset_tick: got %b want 0", sec_tick); end
    repeat (2) @(negedge clk);
    tests++;
    if (observed() !== 16'h0) begin fails++; $display("[TB] FAIL reset_hold: got %h want 0", observed()); end
    rst = 1'b1;
  endtask

  task automatic test_seconds();
    int ticks = 0;
    int first = 0;
    for (int i = 1; i <= 6 * TICK_DIV; i++) begin
      step();
      tests++;
      if (observed() !== expected()) begin
        fails++; $display("[TB] FAIL seconds cyc %0d: got %h want %h", i, observed(), expected());
      end
      // sampled after edge i, so the pulse occupies cycle i+1
      if (sec_tick === 1'b1) begin
        ticks++;
        if (first == 0) first = i + 1;
      end
    end
    tests++; if (ticks != 6) begin fails++; $display("[TB] FAIL tick_count: got %0d want 6", ticks); end
    tests++; if (first != 4) begin fails++; $display("[TB] FAIL first_tick: got cycle %0d want 4", first); end
    step();
    tests++;
    if (an !== 6'b000001 || seg !== 7'h5f) begin
      fails++; $display("[TB] FAIL ss_units_06: got an=%b seg=%h want an=000001 seg=5f", an, seg);
    end
  endtask

  task automatic test_rollover();
    bit wrapped = 0;
    set_field(2'b01, 23);
    set_field(2'b10, 59);
    set_sel = 2'b00;
    step();
    tests++; if (pm !== 1'b1) begin fails++; $display("[TB] FAIL pm_at_23: got %b want 1", pm); end
    for (int i = 0; i < 400; i++) begin
      step();
      tests++;
      if (observed() !== expected()) begin
        fails++; $display("[TB] FAIL rollover cyc %0d: got %h want %h", i, observed(), expected());
      end
      if (m_hh == 0 && m_mm == 0 && m_ss == 0) begin wrapped = 1; break; end
    end
    tests++;
    if (!wrapped) begin fails++; $display("[TB] FAIL rollover_timeout: got no wrap want 00:00:00"); end
    tests++; if (pm !== 1'b1) begin fails++; $display("[TB] FAIL pm_wrap_edge: got %b want 1", pm); end
    step();
    tests++; if (pm !== 1'b0) begin fails++; $display("[TB] FAIL pm_after_wrap: got %b want 0", pm); end
  endtask

  task automatic test_back_to_back();
    bit seen_t = 0, seen_u = 0;
    set_sel = 2'b01;
    inc = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      tests++;
      if (observed() !== expected()) begin
        fails++; $display("[TB] FAIL b2b_inc cyc %0d: got %h want %h", i, observed(), expected());
      end
    end
    inc = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      tests++;
      if (observed() !== expected()) begin
        fails++; $display("[TB] FAIL set_frozen cyc %0d: got %h want %h", i, observed(), expected());
      end
    end
    set_sel = 2'b10;
    for (int i = 0; i < 14; i++) begin
      step();
      if (an === 6'b100000) begin
        seen_t = 1; tests++;
        if (seg !== 7'h7e) begin fails++; $display("[TB] FAIL hh_tens_wrap: got %h want 7e", seg); end
      end
      if (an === 6'b010000) begin
        seen_u = 1; tests++;
        if (seg !== 7'h7e) begin fails++; $display("[TB] FAIL hh_units_wrap: got %h want 7e", seg); end
      end
    end
    tests++;
    if (!(seen_t && seen_u)) begin fails++; $display("[TB] FAIL hh_scan_timeout: got t=%0d u=%0d want 1 1", seen_t, seen_u); end
  endtask

  task automatic test_inc_ignored_in_run();
    set_sel = 2'b00;
    inc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (observed() !== expected()) begin
        fails++; $display("[TB] FAIL run_inc cyc %0d: got %h want %h", i, observed(), expected());
      end
    end
    inc = 1'b0;
  endtask

  task automatic test_12h();
    int         tgt   [3] = '{0, 13, 9};
    logic [6:0] exp_t [3] = '{7'h30, 7'h00, 7'h00};
    logic [6:0] exp_u [3] = '{7'h6d, 7'h30, 7'h7b};
    logic       exp_pm[3] = '{1'b0, 1'b1, 1'b0};
    mode_24 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bit seen_t = 0, seen_u = 0;
      set_field(2'b01, tgt[k]);
      set_sel = 2'b10;
      for (int i = 0; i < 14; i++) begin
        step();
        tests++;
        if (observed() !== expected()) begin
          fails++; $display("[TB] FAIL h12_%0d cyc %0d: got %h want %h", tgt[k], i, observed(), expected());
        end
        if (an === 6'b100000) begin
          seen_t = 1; tests++;
          if (seg !== exp_t[k]) begin fails++; $display("[TB] FAIL h12_tens_%0d: got %h want %h", tgt[k], seg, exp_t[k]); end
        end
        if (an === 6'b010000) begin
          seen_u = 1; tests++;
          if (seg !== exp_u[k]) begin fails++; $display("[TB] FAIL h12_units_%0d: got %h want %h", tgt[k], seg, exp_u[k]); end
        end
      end
      tests++;
      if (!(seen_t && seen_u)) begin fails++; $display("[TB] FAIL h12_scan_%0d: got t=%0d u=%0d want 1 1", tgt[k], seen_t, seen_u); end
      tests++;
      if (pm !== exp_pm[k]) begin fails++; $display("[TB] FAIL h12_pm_%0d: got %b want %b", tgt[k], pm, exp_pm[k]); end
    end
    mode_24 = 1'b1;
    set_sel = 2'b00;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) set_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) mode_24 = ~mode_24;
      inc = ($urandom_range(0, 2) == 0);
      step();
      tests++;
      if (observed() !== expected()) begin
        fails++; $display("[TB] FAIL random cyc %0d: got %h want %h", i, observed(), expected());
      end
    end
    inc = 1'b0;
    set_sel = 2'b00;
    mode_24 = 1'b1;
  endtask

  task automatic test_async_reset();
    bit reached = 0;
    set_field(2'b01, 12);
    set_field(2'b10, 34);
    set_sel = 2'b00;
    for (int i = 0; i < 300; i++) begin
      step();
      tests++;
      if (observed() !== expected()) begin
        fails++; $display("[TB] FAIL pre_reset cyc %0d: got %h want %h", i, observed(), expected());
      end
      if (m_ss == 56) begin reached = 1; break; end
    end
    tests++;
    if (!reached) begin fails++; $display("[TB] FAIL reach_123456: got ss=%0d want 56", m_ss); end
    #2 rst = 1'b0;
    mdl_reset();
    #1;
    tests++; if (an !== '0)   begin fails++; $display("[TB] FAIL async_an: got %b want 0", an); end
    tests++; if (seg !== '0)  begin fails++; $display("[TB] FAIL async_seg: got %h want 0", seg); end
    tests++; if (dp !== 1'b0) begin fails++; $display("[TB] FAIL async_dp: got %b want 0", dp); end
    tests++; if (pm !== 1'b0) begin fails++; $display("[TB] FAIL async_pm: got %b want 0", pm); end
    tests++; if (sec_tick !== 1'b0) begin fails++; $display("[TB] FAIL async_tick: got %b want 0", sec_tick); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    tests++;
    if (an !== 6'b000001 || seg !== 7'h7e) begin
      fails++; $display("[TB] FAIL restart_zero: got an=%b seg=%h want an=000001 seg=7e", an, seg);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      tests++;
      if (observed() !== expected()) begin
        fails++; $display("[TB] FAIL restart cyc %0d: got %h want %h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_seconds();
    test_rollover();
    test_back_to_back();
    test_inc_ignored_in_run();
    test_12h();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
